// File: rtl/target_hit_judge.sv
// target_hit_judge: debounces the player's button, judges each press against the target LED,
// keeps a saturating score and drives direction/freeze back to the LED runner.
module target_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SHOW_CYCLES     = 13500000,
  parameter int TARGET_BIT      = 5,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_n,
  input  logic [5:0]         LED_INDEX,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic               right,
  output logic               freeze
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(SHOW_CYCLES + 1);
  localparam logic [5:0] TARGET = 6'(1 << TARGET_BIT);
  typedef enum logic [1:0] {IDLE, SHOW, WAIT_REL} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic hit_q, hit_d, miss_q, miss_d, right_q, right_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic stable, done, press, judge;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= '0;
      right_q <= 1'b1;
    end else begin
      s1_q    <= btn_n;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      timer_q <= timer_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      right_q <= right_d;
    end
  end
  // The counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    stable = s2_q == deb_q;
    done   = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d  = (stable || done) ? '0 : cnt_q + 1'b1;
    deb_d  = (!stable && done) ? s2_q : deb_q;
    press  = deb_q & ~deb_d;
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:     if (press) begin
                  state_d = SHOW;
                  timer_d = TW'(SHOW_CYCLES - 1);
                end
      SHOW:     if (timer_q == '0) state_d = deb_q ? IDLE : WAIT_REL;
                else timer_d = timer_q - 1'b1;
      WAIT_REL: if (deb_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    judge   = (state_q == IDLE) && press;
    hit_d   = judge && (LED_INDEX == TARGET);
    miss_d  = judge && (LED_INDEX != TARGET);
    score_d = (hit_d && score_q != '1) ? score_q + 1'b1 : score_q;
    right_d = right_q ^ hit_d;
  end
  assign hit    = hit_q;
  assign miss   = miss_q;
  assign score  = score_q;
  assign right  = right_q;
  assign freeze = state_q == SHOW;
endmodule

// File: tb/tb_target_hit_judge.sv
// tb_target_hit_judge: random presses scored by a queue-based reference model and a decoupled monitor.
module tb_target_hit_judge;
  logic clk = 0, rst, btn_n;
  logic [5:0] LED_INDEX;
  logic hit, miss, right, freeze;
  logic [7:0] score;
  typedef struct {logic h; logic [7:0] s; logic r;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int m_score = 0;
  logic m_right = 1;
  target_hit_judge #(.DEBOUNCE_CYCLES(4), .SHOW_CYCLES(8), .TARGET_BIT(5), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .LED_INDEX(LED_INDEX),
    .hit(hit), .miss(miss), .score(score), .right(right), .freeze(freeze)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int x);
    total++;
    if (a != x) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, x, $time);
    end
  endtask
  task automatic do_press(input logic [5:0] led, input int hold);
    exp_t e;
    if (led == 6'b100000) begin
      if (m_score != 255) m_score++;
      m_right = ~m_right;
      e.h = 1;
    end else e.h = 0;
    e.s = 8'(m_score);
    e.r = m_right;
    q.push_back(e);
    @(posedge clk); #1;
    LED_INDEX = led;
    btn_n = 0;
    repeat (hold) @(posedge clk);
    #1 btn_n = 1;
    repeat (22) @(posedge clk);
  endtask
  task automatic glitch(input int n);
    @(posedge clk); #1;
    btn_n = 0;
    repeat (n) @(posedge clk);
    #1 btn_n = 1;
    repeat (12) @(posedge clk);
  endtask
  function automatic logic [5:0] rand_led();
    logic [5:0] v;
    case ($urandom_range(0, 3))
      0: v = 6'b100000;
      1: v = 6'(1 << $urandom_range(0, 5));
      2: v = 6'b0;
      default: v = 6'($urandom);
    endcase
    return v;
  endfunction
  int frz_run = 0;
  logic prev_frz = 0, prev_pulse = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      frz_run = 0;
      prev_frz = 0;
      prev_pulse = 0;
    end else begin
      if (hit || miss) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got hit=%0b miss=%0b want none at %0t", hit, miss, $time);
        end else begin
          e = q.pop_front();
          chk("hit", int'(hit), int'(e.h));
          chk("miss", int'(miss), int'(!e.h));
          chk("score", int'(score), int'(e.s));
          chk("right", int'(right), int'(e.r));
          chk("freeze_on_judge", int'(freeze), 1);
          chk("no_back_to_back", int'(prev_pulse), 0);
        end
      end
      if (freeze) frz_run++;
      else if (prev_frz) begin
        chk("freeze_len", frz_run, 8);
        frz_run = 0;
      end
      prev_frz = freeze;
      prev_pulse = hit | miss;
    end
  end
  initial begin
    rst = 1;
    btn_n = 1;
    LED_INDEX = 6'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_right", int'(right), 1);
    chk("rst_freeze", int'(freeze), 0);
    @(negedge clk) rst = 0;
    repeat (3) @(posedge clk);
    do_press(6'b100000, 10);
    do_press(6'b000100, 10);
    glitch(2);
    glitch(1);
    do_press(6'b100000, 40);
    do_press(6'b100000, 10);
    do_press(6'b000000, 10);
    do_press(6'b100001, 10);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 2));
      do_press(rand_led(), $urandom_range(8, 30));
    end
    while (m_score != 255) do_press(6'b100000, 8);
    do_press(6'b100000, 8);
    do_press(6'b100000, 8);
    do_press(6'b010000, 8);
    begin
      exp_t e;
      m_score = m_score == 255 ? 255 : m_score + 1;
      m_right = ~m_right;
      e.h = 1; e.s = 8'(m_score); e.r = m_right;
      q.push_back(e);
      @(posedge clk); #1;
      LED_INDEX = 6'b100000;
      btn_n = 0;
      for (int i = 0; i < 30 && !freeze; i++) begin
        @(posedge clk); #1;
      end
      chk("freeze_seen_before_reset", int'(freeze), 1);
      repeat (2) @(posedge clk);
      #2 rst = 1;
      #1;
      chk("async_rst_freeze", int'(freeze), 0);
      chk("async_rst_score", int'(score), 0);
      chk("async_rst_right", int'(right), 1);
      m_score = 0;
      m_right = 1;
      btn_n = 1;
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 0;
      repeat (20) @(posedge clk);
    end
    do_press(6'b100000, 10);
    do_press(6'b001000, 10);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
